mem_burst_master: RTL

Initiator for the 512x32 single-port synchronous RAM. It turns datapath burst requests (start address, length, direction) into per-cycle RAM address/write strobes, and returns read data with valid flags. It sits between the CPU datapath (MAR/MDR side) and the RAM. It hides the RAM's one-cycle read latency and handles address wrap-around.

---
 rtl/mem_burst_master.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_burst_master.sv
// ============================================================================
//  Module      : mem_burst_master
//  Description : Burst initiator for a 512x32 single-port synchronous RAM.
//                Turns start/length/direction requests into per-cycle RAM
//                strobes and returns read beats with a valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_burst_master #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] ONE_LEN  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W:0]    remaining_q;
    logic              rdata_valid_q;
    logic [LEN_W:0]    len_d;

    // A zero length field encodes the maximum burst of 2^LEN_W beats.
    assign len_d = (req_len == '0) ? FULL_LEN : {1'b0, req_len};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= S_IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            // RAM output lags its address by one cycle, so the valid flag does too.
            rdata_valid_q <= (state_q == S_READ);
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        cur_addr_q  <= req_addr;
                        remaining_q <= len_d;
                        state_q     <= req_write ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    cur_addr_q  <= cur_addr_q + ONE_ADDR;
                    remaining_q <= remaining_q - ONE_LEN;
                    if (remaining_q == ONE_LEN) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                end
                S_WRITE: begin
                    if (wdata_valid) begin
                        cur_addr_q  <= cur_addr_q + ONE_ADDR;
                        remaining_q <= remaining_q - ONE_LEN;
                        if (remaining_q == ONE_LEN) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The reset term keeps req_ready low while clr is held, even though the state reads IDLE.
    assign req_ready   = (state_q == S_IDLE) & clr;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign wdata_ready = (state_q == S_WRITE);
    assign mem_write   = wdata_ready & wdata_valid;
    assign mem_addr    = cur_addr_q;
    assign mem_dataIn  = wdata;
    assign rdata       = mem_dataOut;
    assign rdata_valid = rdata_valid_q;

endmodule

`default_nettype wire
